// File: rtl/user_stream_arbiter.sv
// -----------------------------------------------------------------------------
// user_stream_arbiter
//
// Purpose:
//   Round-robin arbiter that lets NUM_REQ user-kernel output streams share the
//   single user-input port of a page leaf interface. Requesters talk ap_vld /
//   ap_ack. The leaf side sees a registered valid/ready pair. A granted
//   requester keeps the port for up to MAX_BURST consecutive words, or until it
//   drops its valid. The search then resumes at the next requester in
//   round-robin order.
//
// Ports:
//   clk          : single clock, all state updates on the rising edge
//   reset        : synchronous, active-high
//   req_data     : requester i data in bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_vld      : per-requester ap_vld
//   req_ack      : per-requester ap_ack (a word moves when vld & ack)
//   out_data     : registered word to the leaf i_user_data
//   out_vld      : registered leaf i_user_valid
//   out_ready    : leaf o_user_ready
//   grant_id     : index of the current or last granted requester
//   grant_active : high while a requester holds the grant
//   word_cnt     : total words accepted from requesters, wraps modulo 2^32
// -----------------------------------------------------------------------------
module user_stream_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int MAX_BURST    = 8,
    localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BW          = $clog2(MAX_BURST + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_vld,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [PAYLOAD_BITS-1:0]         out_data,
    output logic                            out_vld,
    input  logic                            out_ready,
    output logic [GW-1:0]                   grant_id,
    output logic                            grant_active,
    output logic [31:0]                     word_cnt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_id_q, grant_id_d;
    logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]           burst_cnt_q, burst_cnt_d;
    logic [PAYLOAD_BITS-1:0] out_data_q, out_data_d;
    logic                    out_vld_q, out_vld_d;
    logic [31:0]             word_cnt_q, word_cnt_d;

    logic                    space;
    logic                    granted_vld;
    logic [PAYLOAD_BITS-1:0] granted_data;
    logic                    accept;
    logic [BW-1:0]           burst_inc;
    logic [GW-1:0]           next_ptr;
    logic                    pick_found;
    logic [GW-1:0]           pick_idx;
    logic [GW-1:0]           cand_sel;
    int                      cand_idx;

    // The output register can take a new word when it is empty, or when the
    // word it holds leaves in this same cycle. This lets data flow at full
    // rate with no bubble.
    assign space       = !out_vld_q || out_ready;
    assign granted_vld = req_vld[grant_id_q];
    assign accept      = (state_q == GRANT) && granted_vld && space;
    assign burst_inc   = burst_cnt_q + BW'(1);
    assign next_ptr    = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);

    // Select the slice that belongs to the granted requester.
    always_comb begin
        granted_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_id_q) begin
                granted_data = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // Search for the first valid requester, starting at rr_ptr and wrapping
    // modulo NUM_REQ. The candidate index is formed in int arithmetic so the
    // wrap also works when NUM_REQ is not a power of two.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = 0;
        cand_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = int'(rr_ptr_q) + k;
            if (cand_idx >= NUM_REQ) begin
                cand_idx = cand_idx - NUM_REQ;
            end
            cand_sel = GW'(cand_idx);
            if (!pick_found && req_vld[cand_sel]) begin
                pick_found = 1'b1;
                pick_idx   = cand_sel;
            end
        end
    end

    // Next-state logic for the arbitration FSM.
    // req_ack is built only from registers and out_ready, never from req_vld,
    // so a requester can wait on ack without creating a combinational loop.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        req_ack     = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                req_ack[grant_id_q] = space;
                if (accept) begin
                    burst_cnt_d = burst_inc;
                    if (burst_inc == BW'(MAX_BURST)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (!granted_vld) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register and word counter. The register drains independently of
    // the FSM, so a word loaded just before release is still delivered.
    always_comb begin
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        word_cnt_d = word_cnt_q;
        if (accept) begin
            out_data_d = granted_data;
            out_vld_d  = 1'b1;
            word_cnt_d = word_cnt_q + 32'd1;
        end else if (out_vld_q && out_ready) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            out_data_q  <= '0;
            out_vld_q   <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            out_data_q  <= out_data_d;
            out_vld_q   <= out_vld_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_vld      = out_vld_q;
    assign grant_id     = grant_id_q;
    assign grant_active = (state_q == GRANT);
    assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_user_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_user_stream_arbiter
//
// Directed bench for user_stream_arbiter with the default parameters
// (4 requesters, 32-bit words, burst of 8). Each requester i offers words
// (i << 28) + n, where n counts up from 1. The bench steps to the next word
// when it sees its ack taken.
// -----------------------------------------------------------------------------
module tb_user_stream_arbiter;

    localparam int NUM_REQ = 4;
    localparam int PB      = 32;

    logic                    clk;
    logic                    reset;
    logic [NUM_REQ*PB-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_vld;
    logic [NUM_REQ-1:0]      req_ack;
    logic [PB-1:0]           out_data;
    logic                    out_vld;
    logic                    out_ready;
    logic [1:0]              grant_id;
    logic                    grant_active;
    logic [31:0]             word_cnt;

    int                      checks;
    int                      failures;
    logic [NUM_REQ-1:0]      want;
    logic [NUM_REQ-1:0]      took;
    int                      sent [NUM_REQ];
    int                      limit [NUM_REQ];

    user_stream_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .PAYLOAD_BITS (PB),
        .MAX_BURST    (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_data     (req_data),
        .req_vld      (req_vld),
        .req_ack      (req_ack),
        .out_data     (out_data),
        .out_vld      (out_vld),
        .out_ready    (out_ready),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .word_cnt     (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive each requester from its sent count. A requester stays valid while
    // it wants to send and still has words left.
    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vld[i]            = want[i] && (sent[i] < limit[i]);
            req_data[i*PB +: PB]  = (32'(i) << 28) + 32'(sent[i] + 1);
        end
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Any handshake seen before the edge counts as a
    // transfer unless reset is active. Inputs for the next cycle are then
    // applied and given time to settle.
    task automatic step();
        took = req_vld & req_ack;
        @(posedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (took[i]) sent[i]++;
            end
        end
        applyStimulus();
        #1;
    endtask

    task automatic doReset();
        want  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sent[i]  = 0;
            limit[i] = 1000;
        end
        out_ready = 1'b1;
        reset     = 1'b1;
        applyStimulus();
        #1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        req_data = '0;
        req_vld  = '0;
        doReset();

        // Reset values
        checkOutput("rst_out_vld",  64'(out_vld),         64'd0);
        checkOutput("rst_out_data", 64'(out_data),        64'd0);
        checkOutput("rst_ack",      64'(req_ack),         64'd0);
        checkOutput("rst_grant_id", 64'(grant_id),        64'd0);
        checkOutput("rst_active",   64'(grant_active),    64'd0);
        checkOutput("rst_word_cnt", 64'(word_cnt),        64'd0);
        checkOutput("rst_rr_ptr",   64'(dut.rr_ptr_q),    64'd0);
        checkOutput("rst_burst",    64'(dut.burst_cnt_q), 64'd0);

        // Single stream: 16 words from requester 0. A bubble is expected after word 8.
        want     = 4'b0001;
        limit[0] = 16;
        applyStimulus();
        #1;
        checkOutput("ss_ack_c0", 64'(req_ack), 64'd0);
        for (int c = 1; c <= 19; c++) begin
            logic        ev;
            logic [31:0] ed;
            logic [3:0]  ea;
            step();
            ev = ((c >= 2) && (c <= 9)) || ((c >= 11) && (c <= 18));
            if (c < 2)        ed = 32'd0;
            else if (c <= 9)  ed = 32'(c - 1);
            else if (c == 10) ed = 32'd8;
            else if (c <= 18) ed = 32'(c - 2);
            else              ed = 32'd16;
            ea = (((c >= 1) && (c <= 8)) || ((c >= 10) && (c <= 17))) ? 4'b0001 : 4'b0000;
            checkOutput($sformatf("ss_vld_c%0d", c),  64'(out_vld),  64'(ev));
            checkOutput($sformatf("ss_data_c%0d", c), 64'(out_data), 64'(ed));
            checkOutput($sformatf("ss_ack_c%0d", c),  64'(req_ack),  64'(ea));
            checkOutput($sformatf("ss_gid_c%0d", c),  64'(grant_id), 64'd0);
        end
        checkOutput("ss_word_cnt", 64'(word_cnt), 64'd16);

        // Fairness: all four requesters valid. Bursts of 8 go in order 0,1,2,3,0.
        doReset();
        want = 4'b1111;
        applyStimulus();
        #1;
        for (int c = 1; c <= 45; c++) begin
            int b;
            int p;
            int r;
            step();
            b = (c - 1) / 9;
            p = (c - 1) % 9;
            r = b % 4;
            if (p == 0) begin
                checkOutput($sformatf("fair_gid_c%0d", c),    64'(grant_id),     64'(r));
                checkOutput($sformatf("fair_active_c%0d", c), 64'(grant_active), 64'd1);
                checkOutput($sformatf("fair_bubble_c%0d", c), 64'(out_vld),      64'd0);
            end else begin
                checkOutput($sformatf("fair_data_c%0d", c),
                            64'(out_data), 64'((32'(r) << 28) + 32'(8 * (b / 4) + p)));
                checkOutput($sformatf("fair_vld_c%0d", c), 64'(out_vld), 64'd1);
            end
        end
        checkOutput("fair_word_cnt", 64'(word_cnt), 64'd40);

        // Backpressure: out_ready is held low for 5 cycles after word 3.
        doReset();
        want     = 4'b0001;
        limit[0] = 8;
        applyStimulus();
        #1;
        step();
        step();
        step();
        step();
        checkOutput("bp_data_w3", 64'(out_data), 64'd3);
        out_ready = 1'b0;
        #1;
        checkOutput("bp_ack_drop", 64'(req_ack), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("bp_hold_data_%0d", k),  64'(out_data),        64'd3);
            checkOutput($sformatf("bp_hold_vld_%0d", k),   64'(out_vld),         64'd1);
            checkOutput($sformatf("bp_hold_ack_%0d", k),   64'(req_ack),         64'd0);
            checkOutput($sformatf("bp_hold_burst_%0d", k), 64'(dut.burst_cnt_q), 64'd3);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ack_back", 64'(req_ack), 64'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("bp_resume_data_%0d", k), 64'(out_data), 64'(4 + k));
            checkOutput($sformatf("bp_resume_vld_%0d", k),  64'(out_vld),  64'd1);
        end
        step();
        checkOutput("bp_drain_vld",  64'(out_vld),  64'd0);
        checkOutput("bp_drain_data", 64'(out_data), 64'd8);
        checkOutput("bp_word_cnt",   64'(word_cnt), 64'd8);

        // Early release: requester 2 stops after 3 words while requester 3 waits.
        doReset();
        want     = 4'b1100;
        limit[2] = 3;
        applyStimulus();
        #1;
        step();
        checkOutput("er_gid_2",    64'(grant_id),     64'd2);
        checkOutput("er_active_2", 64'(grant_active), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("er_data_%0d", k), 64'(out_data), 64'(32'h2000_0001 + 32'(k)));
        end
        step();
        checkOutput("er_idle_active", 64'(grant_active), 64'd0);
        checkOutput("er_idle_ack",    64'(req_ack),      64'd0);
        checkOutput("er_rr_ptr",      64'(dut.rr_ptr_q), 64'd3);
        checkOutput("er_idle_vld",    64'(out_vld),      64'd0);
        step();
        checkOutput("er_gid_3",    64'(grant_id),     64'd3);
        checkOutput("er_active_3", 64'(grant_active), 64'd1);
        checkOutput("er_ack_3",    64'(req_ack),      64'b1000);
        step();
        checkOutput("er_data_r3",  64'(out_data), 64'h3000_0001);
        checkOutput("er_vld_r3",   64'(out_vld),  64'd1);
        checkOutput("er_word_cnt", 64'(word_cnt), 64'd4);

        // Reset mid-burst with a word still in the output register. After
        // reset, requester 0 must win over requester 3 because rr_ptr restarts at 0.
        want  = 4'b1001;
        reset = 1'b1;
        applyStimulus();
        #1;
        step();
        reset = 1'b0;
        checkOutput("mr_out_vld",  64'(out_vld),      64'd0);
        checkOutput("mr_ack",      64'(req_ack),      64'd0);
        checkOutput("mr_word_cnt", 64'(word_cnt),     64'd0);
        checkOutput("mr_gid",      64'(grant_id),     64'd0);
        checkOutput("mr_active",   64'(grant_active), 64'd0);
        step();
        checkOutput("mr_regrant_gid",    64'(grant_id),     64'd0);
        checkOutput("mr_regrant_active", 64'(grant_active), 64'd1);
        step();
        checkOutput("mr_regrant_data", 64'(out_data), 64'h0000_0001);

        // Wrap: preload the word counter to all ones, then accept one word.
        doReset();
        force dut.word_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.word_cnt_q;
        #1;
        checkOutput("wrap_preload", 64'(word_cnt), 64'hFFFF_FFFF);
        want     = 4'b0001;
        limit[0] = 1;
        applyStimulus();
        #1;
        step();
        step();
        checkOutput("wrap_word_cnt", 64'(word_cnt), 64'h0000_0000);
        checkOutput("wrap_data",     64'(out_data), 64'h0000_0001);
        checkOutput("wrap_vld",      64'(out_vld),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
